// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: XLEN, reset/NOP defaults and the
// fetch entry that moves from IF to ID.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with synchronous flush. The head
// entry is read straight from storage; a push becomes visible on the next cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty
);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a synchronous imem,
// buffers responses in a prefetch FIFO and hands {instr, pc} to ID.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_valid,
    input  logic            id_ready,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic            inflight;
    logic            epoch;
    logic [XLEN-1:0] req_pc;
    logic            req_epoch;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_push_data;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            fifo_push;
    logic            pop;
    logic            issue;
    int unsigned     occupancy;

    assign id_valid = ~fifo_empty;
    assign id_instr = id_valid ? fifo_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? fifo_head.pc : '0;
    assign pop      = id_valid & id_ready;

    // Slots already claimed by buffered entries plus the outstanding read.
    assign occupancy = 32'(fifo_count) + 32'(inflight) - 32'(pop);
    assign issue     = ~rst & ~br_taken & (occupancy < FIFO_DEPTH);
    assign imem_en   = issue;
    assign imem_addr = fetch_pc;

    assign fifo_push      = inflight & (req_epoch == epoch) & ~br_taken & ~rst;
    assign fifo_push_data = '{pc: req_pc, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            req_pc    <= RESET_PC;
            req_epoch <= 1'b0;
        end else if (br_taken) begin
            fetch_pc <= br_target & ~32'h0000_0003;
            inflight <= 1'b0;
            epoch    <= ~epoch;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + 32'd4;
                req_pc    <= fetch_pc;
                req_epoch <= epoch;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop),
        .flush     (br_taken),
        .count     (fifo_count),
        .head      (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall, redirect, reset and PC wrap
// against a one-cycle-latency instruction memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_ready;
    logic        br_taken;
    logic [31:0] br_target;

    int n_checks = 0;
    int n_pass   = 0;

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    // Program image: 003E0313 @0, 006E0333 @4, stepping by 00300020 per word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h003E_0313 + (a >> 2) * 32'h0030_0020;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic start_cycle(input logic ready, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        id_ready  = ready;
        br_taken  = br;
        br_target = tgt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_en !== 1'b0) $display("FAIL reset_imem_en: got %b want 0", imem_en); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr: got %h want 00000000", imem_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== 32'h0000_0013) $display("FAIL reset_id_instr: got %h want 00000013", id_instr); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 00000000", id_pc); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            start_cycle(1'b1, 1'b0, '0);
            n_checks++; if (imem_en !== 1'b1) $display("FAIL stream_en c%0d: got %b want 1", c, imem_en); else n_pass++;
            n_checks++; if (imem_addr !== 32'(4 * c)) $display("FAIL stream_addr c%0d: got %h want %h", c, imem_addr, 32'(4 * c)); else n_pass++;
            n_checks++; if (id_valid !== (c >= 2)) $display("FAIL stream_valid c%0d: got %b want %b", c, id_valid, c >= 2); else n_pass++;
            if (c >= 2) begin
                n_checks++; if (id_pc !== 32'(4 * (c - 2))) $display("FAIL stream_pc c%0d: got %h want %h", c, id_pc, 32'(4 * (c - 2))); else n_pass++;
                n_checks++; if (id_instr !== mem_word(32'(4 * (c - 2)))) $display("FAIL stream_instr c%0d: got %h want %h", c, id_instr, mem_word(32'(4 * (c - 2)))); else n_pass++;
            end
            if (c == 3) begin
                n_checks++; if (id_instr !== 32'h006E_0333) $display("FAIL stream_instr4: got %h want 006e0333", id_instr); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b0, '0);
        for (int c = 2; c < 7; c++) begin
            start_cycle(1'b0, 1'b0, '0);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL stall_valid c%0d: got %b want 1", c, id_valid); else n_pass++;
            n_checks++; if (id_pc !== 32'h0) $display("FAIL stall_pc c%0d: got %h want 00000000", c, id_pc); else n_pass++;
            n_checks++; if (id_instr !== 32'h003E_0313) $display("FAIL stall_instr c%0d: got %h want 003e0313", c, id_instr); else n_pass++;
            n_checks++; if (imem_en !== 1'b0) $display("FAIL stall_en c%0d: got %b want 0", c, imem_en); else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            start_cycle(1'b1, 1'b0, '0);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL release_valid k%0d: got %b want 1", k, id_valid); else n_pass++;
            n_checks++; if (id_pc !== exp_pc[k]) $display("FAIL release_pc k%0d: got %h want %h", k, id_pc, exp_pc[k]); else n_pass++;
            if (k < 2) begin
                n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'(8 + 4 * k)) $display("FAIL release_issue k%0d: got en=%b addr=%h want en=1 addr=%h", k, imem_en, imem_addr, 32'(8 + 4 * k)); else n_pass++;
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 6; c++) start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b1, 32'h0000_0100);
        n_checks++; if (imem_en !== 1'b0) $display("FAIL redir_no_issue: got %b want 0", imem_en); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL redir_n1_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h100) $display("FAIL redir_n1_issue: got en=%b addr=%h want en=1 addr=00000100", imem_en, imem_addr); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL redir_n2_valid: got %b want 0", id_valid); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) $display("FAIL redir_n3_pc: got v=%b pc=%h want v=1 pc=00000100", id_valid, id_pc); else n_pass++;
        n_checks++; if (id_instr !== mem_word(32'h100)) $display("FAIL redir_n3_instr: got %h want %h", id_instr, mem_word(32'h100)); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h104) $display("FAIL redir_n4_pc: got v=%b pc=%h want v=1 pc=00000104", id_valid, id_pc); else n_pass++;
    endtask

    task automatic test_redirect_stalled();
        do_reset();
        start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b0, 1'b1, 32'h0000_0203);
        start_cycle(1'b0, 1'b0, '0);
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rstall_issue: got en=%b addr=%h want en=1 addr=00000200", imem_en, imem_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rstall_flushed: got %b want 0", id_valid); else n_pass++;
        start_cycle(1'b0, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rstall_stale: got v=%b pc=%h want v=0", id_valid, id_pc); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            start_cycle(1'b0, 1'b0, '0);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200) $display("FAIL rstall_first c%0d: got v=%b pc=%h want v=1 pc=00000200", c, id_valid, id_pc); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 3; c++) start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b1, 32'h0000_0300);
        start_cycle(1'b1, 1'b1, 32'h0000_0400);
        n_checks++; if (imem_en !== 1'b0) $display("FAIL b2b_no_issue: got %b want 0", imem_en); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (imem_addr !== 32'h400 || id_valid !== 1'b0) $display("FAIL b2b_issue: got addr=%h v=%b want addr=00000400 v=0", imem_addr, id_valid); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL b2b_stale: got v=%b pc=%h want v=0", id_valid, id_pc); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h400) $display("FAIL b2b_pc: got v=%b pc=%h want v=1 pc=00000400", id_valid, id_pc); else n_pass++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        rst = 1'b1; id_ready = 1'b0;
        @(negedge clk);
        start_cycle(1'b0, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) $display("FAIL midrst_issue: got en=%b addr=%h want en=1 addr=00000000", imem_en, imem_addr); else n_pass++;
        start_cycle(1'b0, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL midrst_stale: got v=%b pc=%h want v=0", id_valid, id_pc); else n_pass++;
        start_cycle(1'b0, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h003E_0313) $display("FAIL midrst_first: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=003e0313", id_valid, id_pc, id_instr); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 3; c++) start_cycle(1'b1, 1'b0, '0);
        start_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr1: got en=%b addr=%h want en=1 addr=00000000", imem_en, imem_addr); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0: got v=%b pc=%h want v=1 pc=fffffffc", id_valid, id_pc); else n_pass++;
        start_cycle(1'b1, 1'b0, '0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL wrap_pc1: got v=%b pc=%h want v=1 pc=00000000", id_valid, id_pc); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stalled();
        test_back_to_back();
        test_reset_midop();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
